// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package bit_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_1b.sv
// Combinational 1-bit full-adder cell; the only arithmetic in the serial adder.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one sum bit per clock through a single full-adder cell,
// registered WIDTH-bit sum and carry-out presented with a one-cycle done pulse.
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             co_bit;
    logic             load;
    logic             last;

    full_adder_1b u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s_bit),
        .co (co_bit)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // acc needs no clearing on load: WIDTH shifts overwrite every bit before it is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= co_bit;
            acc   <= {s_bit, acc[WIDTH-1:1]};
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= {s_bit, acc[WIDTH-1:1]};
                cout <= co_bit;
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: scenario tasks plus a scoreboard monitor on done.
module tb_bit_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH:0] sb_q[$];
    logic           prev_done;
    int             done_seen;

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                done_seen++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got done with sum=%h cout=%b, required no done", sum, cout);
                end else begin
                    logic [WIDTH:0] exp;
                    exp = sb_q.pop_front();
                    if ({cout, sum} !== exp) begin
                        failures++;
                        $display("FAIL scoreboard: got {cout,sum}=%h, required %h", {cout, sum}, exp);
                    end
                end
            end
            checks++;
            if (done && prev_done) begin
                failures++;
                $display("FAIL done_twice: done high on 2 consecutive cycles, required single pulse");
            end
            checks++;
            if (busy && done) begin
                failures++;
                $display("FAIL busy_and_done: busy=1 done=1, required not both");
            end
            prev_done = done;
        end
    end

    // Caller is at a falling edge; returns at the falling edge after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        start = 1'b1;
        a     = x;
        b     = y;
        cin   = c;
        sb_q.push_back(model(x, y, c));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: done not seen within 40 cycles, required done", name);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        start_op(8'h0F, 8'h01, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL basic_busy: cycle %0d busy=%b done=%b, required busy=1 done=0", i, busy, done);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h10 || cout !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: done=%b busy=%b sum=%h cout=%b, required done=1 busy=0 sum=10 cout=0",
                     done, busy, sum, cout);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_pulse: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_carry();
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done("carry1");
        checks++;
        if (sum !== 8'h00 || cout !== 1'b1) begin
            failures++;
            $display("FAIL carry_ripple: sum=%h cout=%b, required sum=00 cout=1", sum, cout);
        end
        @(negedge clk);
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done("carry2");
        checks++;
        if (sum !== 8'hFF || cout !== 1'b1) begin
            failures++;
            $display("FAIL carry_max: sum=%h cout=%b, required sum=ff cout=1", sum, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int base;
        start_op(8'h12, 8'h34, 1'b0);
        base = done_seen;
        repeat (2) @(negedge clk);
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore");
        checks++;
        if (sum !== 8'h46 || cout !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result: sum=%h cout=%b, required sum=46 cout=0", sum, cout);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (done_seen - base !== 1) begin
            failures++;
            $display("FAIL ignore_count: %0d done pulses, required 1", done_seen - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        start_op(8'hFF, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
        end
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        base = done_seen;
        repeat (20) @(negedge clk);
        checks++;
        if (done_seen - base !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: %0d done pulses busy=%b after reset, required 0 and busy=0",
                     done_seen - base, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] last_sum;
        int cyc;
        last_sum = sum;
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
        cin = 1'b1;
        sb_q.push_back(model(a, b, cin));
        @(posedge clk);
        for (int r = 0; r < 4; r++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (!done) begin
                    checks++;
                    if (sum !== last_sum) begin
                        failures++;
                        $display("FAIL b2b_stable: sum=%h between pulses, required %h", sum, last_sum);
                    end
                end
            end while (!done && cyc < 20);
            checks++;
            if (cyc !== WIDTH + 1) begin
                failures++;
                $display("FAIL b2b_period: %0d cycles between results, required %0d", cyc, WIDTH + 1);
            end
            last_sum = sum;
            if (r < 3) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                cin = 1'($urandom);
                sb_q.push_back(model(a, b, cin));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int gap;
        for (int i = 0; i < 1000; i++) begin
            wait_idle();
            if (!done) begin
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
            end else if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
            end
            start_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            while (busy) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() !== 0) begin
            failures++;
            $display("FAIL random_drain: %0d results missing, required 0", sb_q.size());
        end
    endtask

    initial begin
        done_seen = 0;
        prev_done = 1'b0;
        test_reset();
        test_basic();
        wait_idle();
        test_carry();
        wait_idle();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        wait_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
